// File: rtl/sae_arbiter_if.sv
//==============================================================================
// Module   : sae_arbiter_if
// Brief    : Requester, response and SAE-core signal bundle for sae_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface sae_arbiter_if;
    logic       req0_valid;
    logic [1:0] req0_mode;
    logic [7:0] req0_data;
    logic [7:0] req0_key;
    logic       req0_ready;
    logic       req1_valid;
    logic [1:0] req1_mode;
    logic [7:0] req1_data;
    logic [7:0] req1_key;
    logic       req1_ready;

    logic       rsp0_valid;
    logic [7:0] rsp0_data;
    logic [3:0] rsp0_err;
    logic       rsp1_valid;
    logic [7:0] rsp1_data;
    logic [3:0] rsp1_err;

    logic [1:0] core_mode;
    logic [7:0] core_data_input;
    logic [7:0] core_key_input;
    logic       core_inputs_valid;
    logic [7:0] core_data_output;
    logic       core_output_ready;
    logic       core_err_ptxt;
    logic       core_err_seckey;
    logic       core_err_ctxt;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_mode, req0_data, req0_key,
        input  req1_valid, req1_mode, req1_data, req1_key,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_err,
        output rsp1_valid, rsp1_data, rsp1_err,
        output core_mode, core_data_input, core_key_input, core_inputs_valid,
        input  core_data_output, core_output_ready,
        input  core_err_ptxt, core_err_seckey, core_err_ctxt
    );

    // Requesters plus SAE core
    modport master (
        output req0_valid, req0_mode, req0_data, req0_key,
        output req1_valid, req1_mode, req1_data, req1_key,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_err,
        input  rsp1_valid, rsp1_data, rsp1_err,
        input  core_mode, core_data_input, core_key_input, core_inputs_valid,
        output core_data_output, core_output_ready,
        output core_err_ptxt, core_err_seckey, core_err_ctxt
    );
endinterface

`default_nettype wire

// File: rtl/sae_arbiter.sv
//==============================================================================
// Module   : sae_arbiter
// Brief    : Round-robin two-requester front end for a shared SAE core with a
//            response timeout. Define SAE_ARBITER_STATS_EN for grant/timeout
//            statistics counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sae_arbiter #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    sae_arbiter_if.slave bus
`ifdef SAE_ARBITER_STATS_EN
    ,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1,
    output logic [7:0]   timeout_cnt
`endif
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] r_state;
    logic       r_last_grant;
    logic       r_id;
    logic [7:0] r_cnt;

    logic       w_elig0;
    logic       w_elig1;
    logic       w_win1;
    logic       w_grant;
    logic       w_core_done;
    logic       w_timeout;
    logic [7:0] w_cap_data;
    logic [3:0] w_cap_err;

    assign w_elig0 = bus.req0_valid && (bus.req0_mode != 2'b00);
    assign w_elig1 = bus.req1_valid && (bus.req1_mode != 2'b00);
    // r_last_grant resets to 1 so requester 0 wins the first contention
    assign w_win1  = w_elig1 && (!w_elig0 || !r_last_grant);
    assign w_grant = rst_n && (r_state == c_ST_IDLE) && (w_elig0 || w_elig1);

    assign bus.req0_ready = w_grant && !w_win1;
    assign bus.req1_ready = w_grant && w_win1;

    assign w_core_done = (r_state == c_ST_WAIT) &&
                         (bus.core_output_ready || bus.core_err_ptxt ||
                          bus.core_err_seckey  || bus.core_err_ctxt);
    assign w_timeout   = (r_state == c_ST_WAIT) && !w_core_done && (r_cnt == c_TMO_LAST);
    assign w_cap_data  = w_core_done ? bus.core_data_output : 8'h00;
    assign w_cap_err   = w_core_done ?
                         {1'b0, bus.core_err_ctxt, bus.core_err_seckey, bus.core_err_ptxt} :
                         4'b1000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state               <= c_ST_IDLE;
            r_last_grant          <= 1'b1;
            r_id                  <= 1'b0;
            r_cnt                 <= 8'h00;
            bus.core_mode         <= 2'b00;
            bus.core_data_input   <= 8'h00;
            bus.core_key_input    <= 8'h00;
            bus.core_inputs_valid <= 1'b0;
            bus.rsp0_valid        <= 1'b0;
            bus.rsp0_data         <= 8'h00;
            bus.rsp0_err          <= 4'h0;
            bus.rsp1_valid        <= 1'b0;
            bus.rsp1_data         <= 8'h00;
            bus.rsp1_err          <= 4'h0;
        end else begin
            bus.rsp0_valid        <= 1'b0;
            bus.rsp1_valid        <= 1'b0;
            bus.core_inputs_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_id                  <= w_win1;
                        r_last_grant          <= w_win1;
                        bus.core_mode         <= w_win1 ? bus.req1_mode : bus.req0_mode;
                        bus.core_data_input   <= w_win1 ? bus.req1_data : bus.req0_data;
                        bus.core_key_input    <= w_win1 ? bus.req1_key  : bus.req0_key;
                        bus.core_inputs_valid <= 1'b1;
                        r_state               <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_cnt   <= 8'h00;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // Completion is tested first so it wins over a same-cycle expiry
                    if (w_core_done || w_timeout) begin
                        if (r_id) begin
                            bus.rsp1_valid <= 1'b1;
                            bus.rsp1_data  <= w_cap_data;
                            bus.rsp1_err   <= w_cap_err;
                        end else begin
                            bus.rsp0_valid <= 1'b1;
                            bus.rsp0_data  <= w_cap_data;
                            bus.rsp0_err   <= w_cap_err;
                        end
                        bus.core_mode <= 2'b00;
                        r_state       <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef SAE_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0  <= 16'h0000;
            grant_cnt1  <= 16'h0000;
            timeout_cnt <= 8'h00;
        end else begin
            if (bus.req0_ready && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (bus.req1_ready && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
            if (w_timeout && (timeout_cnt != 8'hFF)) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sae_arbiter.sv
//==============================================================================
// Module   : tb_sae_arbiter
// Brief    : Self-checking bench for sae_arbiter: vector table, corner-case
//            sequences and randomized traffic against a cycle-age reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sae_arbiter;

    localparam int TIMEOUT_CYCLES = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sae_arbiter_if bus ();

`ifdef SAE_ARBITER_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    logic [7:0]  timeout_cnt;
`endif

    sae_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SAE_ARBITER_STATS_EN
        ,
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1),
        .timeout_cnt (timeout_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: m_age counts cycles since the accept cycle, -1 when idle
    int         m_age;
    bit         m_resp;
    bit         m_id;
    bit         m_last1;
    logic [1:0] m_mode;
    logic [7:0] m_data;
    logic [7:0] m_key;
    logic [7:0] m_rd [2];
    logic [3:0] m_re [2];
    int         m_grants [2];
    int         m_tmo;

    typedef struct {
        bit         v0;
        logic [1:0] m0;
        bit         v1;
        logic [1:0] m1;
        logic [7:0] cd;
        bit         crdy;
        logic [2:0] cerr;
        bit         r0;
        bit         r1;
        logic [3:0] err;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age   = -1;
        m_resp  = 1'b0;
        m_id    = 1'b0;
        m_last1 = 1'b1;
        m_mode  = 2'b00;
        m_data  = 8'h00;
        m_key   = 8'h00;
        for (int i = 0; i < 2; i++) begin
            m_rd[i]     = 8'h00;
            m_re[i]     = 4'h0;
            m_grants[i] = 0;
        end
        m_tmo = 0;
    endtask

    task automatic drive_core_idle();
        bus.core_output_ready = 1'b0;
        bus.core_data_output  = 8'h00;
        bus.core_err_ptxt     = 1'b0;
        bus.core_err_seckey   = 1'b0;
        bus.core_err_ctxt     = 1'b0;
    endtask

    task automatic drive_idle();
        bus.req0_valid = 1'b0;
        bus.req0_mode  = 2'b00;
        bus.req0_data  = 8'h00;
        bus.req0_key   = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_mode  = 2'b00;
        bus.req1_data  = 8'h00;
        bus.req1_key   = 8'h00;
        drive_core_idle();
    endtask

    // Asserts reset mid-cycle, checks every output is cleared, releases after one edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        check("rst_core_valid", bus.core_inputs_valid, 0);
        check("rst_core_mode", bus.core_mode, 0);
        check("rst_core_data", bus.core_data_input, 0);
        check("rst_core_key", bus.core_key_input, 0);
        check("rst_rsp0_valid", bus.rsp0_valid, 0);
        check("rst_rsp0_data", bus.rsp0_data, 0);
        check("rst_rsp0_err", bus.rsp0_err, 0);
        check("rst_rsp1_valid", bus.rsp1_valid, 0);
        check("rst_rsp1_data", bus.rsp1_data, 0);
        check("rst_rsp1_err", bus.rsp1_err, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: compare all outputs with the model at negedge, then advance the model
    task automatic step();
        bit e0, e1, g_any, g1, busy, done;
        @(negedge clk);
        e0    = bus.req0_valid && (bus.req0_mode != 2'b00);
        e1    = bus.req1_valid && (bus.req1_mode != 2'b00);
        g_any = (m_age < 0) && (e0 || e1);
        g1    = e1 && (!e0 || !m_last1);
        busy  = (m_age >= 1) && !m_resp;
        check("ready0", bus.req0_ready, g_any && !g1);
        check("ready1", bus.req1_ready, g_any && g1);
        check("core_inputs_valid", bus.core_inputs_valid, busy && (m_age == 1));
        check("core_mode", bus.core_mode, busy ? m_mode : 2'b00);
        if (busy) begin
            check("core_data_input", bus.core_data_input, m_data);
            check("core_key_input", bus.core_key_input, m_key);
        end
        check("rsp0_valid", bus.rsp0_valid, m_resp && !m_id);
        check("rsp1_valid", bus.rsp1_valid, m_resp && m_id);
        check("rsp0_data", bus.rsp0_data, m_rd[0]);
        check("rsp0_err", bus.rsp0_err, m_re[0]);
        check("rsp1_data", bus.rsp1_data, m_rd[1]);
        check("rsp1_err", bus.rsp1_err, m_re[1]);

        if (m_resp) begin
            m_resp = 1'b0;
            m_age  = -1;
        end else if (m_age < 0) begin
            if (g_any) begin
                m_id    = g1;
                m_last1 = g1;
                m_mode  = g1 ? bus.req1_mode : bus.req0_mode;
                m_data  = g1 ? bus.req1_data : bus.req0_data;
                m_key   = g1 ? bus.req1_key  : bus.req0_key;
                m_grants[g1]++;
                m_age   = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            done = bus.core_output_ready || bus.core_err_ptxt ||
                   bus.core_err_seckey  || bus.core_err_ctxt;
            if (done) begin
                m_rd[m_id] = bus.core_data_output;
                m_re[m_id] = {1'b0, bus.core_err_ctxt, bus.core_err_seckey, bus.core_err_ptxt};
                m_resp     = 1'b1;
            end else if (m_age - 1 == TIMEOUT_CYCLES) begin
                // WAIT spans ages 2..TIMEOUT_CYCLES+1
                m_rd[m_id] = 8'h00;
                m_re[m_id] = 4'b1000;
                m_resp     = 1'b1;
                m_tmo++;
            end else begin
                m_age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int lat;
        int seen;

        //            v0 m0     v1 m1     cd     rdy cerr    r0 r1 err
        tbl[0] = '{1'b1, 2'b00, 1'b0, 2'b01, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0000};
        tbl[1] = '{1'b1, 2'b01, 1'b1, 2'b10, 8'h5C, 1'b1, 3'b000, 1'b1, 1'b0, 4'b0000};
        tbl[2] = '{1'b1, 2'b10, 1'b1, 2'b10, 8'hA5, 1'b1, 3'b000, 1'b0, 1'b1, 4'b0000};
        tbl[3] = '{1'b0, 2'b10, 1'b1, 2'b11, 8'h3C, 1'b1, 3'b100, 1'b0, 1'b1, 4'b0100};
        tbl[4] = '{1'b1, 2'b10, 1'b1, 2'b10, 8'h11, 1'b0, 3'b010, 1'b1, 1'b0, 4'b0010};
        tbl[5] = '{1'b1, 2'b11, 1'b1, 2'b00, 8'h77, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0001};
        tbl[6] = '{1'b1, 2'b01, 1'b1, 2'b01, 8'hC3, 1'b1, 3'b000, 1'b0, 1'b1, 4'b0000};
        tbl[7] = '{1'b0, 2'b01, 1'b0, 2'b10, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0000};

        drive_idle();
        #2;
        do_reset();

        // Vector table: arbitration decisions and response capture, from reset
        for (int i = 0; i < 8; i++) begin
            bus.req0_valid = tbl[i].v0;
            bus.req0_mode  = tbl[i].m0;
            bus.req0_data  = 8'h10 + 8'(i);
            bus.req0_key   = 8'h2B;
            bus.req1_valid = tbl[i].v1;
            bus.req1_mode  = tbl[i].m1;
            bus.req1_data  = 8'h80 + 8'(i);
            bus.req1_key   = 8'hD4;
            #1;
            check("tbl_ready0", bus.req0_ready, tbl[i].r0);
            check("tbl_ready1", bus.req1_ready, tbl[i].r1);
            step();
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            if (tbl[i].r0 || tbl[i].r1) begin
                step();
                bus.core_output_ready = tbl[i].crdy;
                bus.core_data_output  = tbl[i].cd;
                {bus.core_err_ctxt, bus.core_err_seckey, bus.core_err_ptxt} = tbl[i].cerr;
                step();
                drive_core_idle();
                check("tbl_rsp0_valid", bus.rsp0_valid, tbl[i].r0);
                check("tbl_rsp1_valid", bus.rsp1_valid, tbl[i].r1);
                check("tbl_rsp_data", tbl[i].r0 ? bus.rsp0_data : bus.rsp1_data, tbl[i].cd);
                check("tbl_rsp_err", tbl[i].r0 ? bus.rsp0_err : bus.rsp1_err, tbl[i].err);
                step();
            end
        end

        // Timeout with a silent core
        drive_idle();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_mode  = 2'b01;
        bus.req0_data  = 8'h42;
        bus.req0_key   = 8'h2B;
        step();
        bus.req0_valid = 1'b0;
        lat = 1;
        while (!bus.rsp0_valid && lat < 20) begin
            step();
            lat++;
        end
        check("timeout_latency", lat, TIMEOUT_CYCLES + 2);
        check("timeout_rsp0_err", bus.rsp0_err, 4'b1000);
        check("timeout_rsp0_data", bus.rsp0_data, 8'h00);
        step();
`ifdef SAE_ARBITER_STATS_EN
        check("stats_timeout_cnt", timeout_cnt, 1);
        check("stats_grant_cnt0", grant_cnt0, 1);
`endif

        // Completion on the final WAIT cycle beats expiry
        bus.req1_valid = 1'b1;
        bus.req1_mode  = 2'b10;
        bus.req1_data  = 8'h33;
        bus.req1_key   = 8'h44;
        step();
        bus.req1_valid = 1'b0;
        step();
        repeat (TIMEOUT_CYCLES - 1) step();
        bus.core_output_ready = 1'b1;
        bus.core_data_output  = 8'h99;
        step();
        drive_core_idle();
        check("expiry_tie_rsp1_valid", bus.rsp1_valid, 1);
        check("expiry_tie_rsp1_err", bus.rsp1_err, 4'b0000);
        check("expiry_tie_rsp1_data", bus.rsp1_data, 8'h99);
        step();

        // Mode 00 is never granted
        bus.req0_valid = 1'b1;
        bus.req0_mode  = 2'b00;
        seen = 0;
        repeat (20) begin
            #1;
            if (bus.req0_ready || bus.core_inputs_valid) seen++;
            step();
        end
        check("mode00_no_grant", seen, 0);

        // Reset during WAIT with both requesters waiting
        bus.req0_mode = 2'b11;
        step();
        bus.req0_valid = 1'b0;
        step();
        bus.req0_valid = 1'b1;
        bus.req0_mode  = 2'b10;
        bus.req1_valid = 1'b1;
        bus.req1_mode  = 2'b01;
        #1;
        check("busy_no_ready0", bus.req0_ready, 0);
        check("busy_no_ready1", bus.req1_ready, 0);
        do_reset();
        #1;
        check("post_rst_ready0", bus.req0_ready, 1);
        check("post_rst_ready1", bus.req1_ready, 0);
        step();

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            bus.req0_valid        = ($urandom_range(0, 9) < 6);
            bus.req0_mode         = 2'($urandom_range(0, 3));
            bus.req0_data         = 8'($urandom);
            bus.req0_key          = 8'($urandom);
            bus.req1_valid        = ($urandom_range(0, 9) < 6);
            bus.req1_mode         = 2'($urandom_range(0, 3));
            bus.req1_data         = 8'($urandom);
            bus.req1_key          = 8'($urandom);
            bus.core_output_ready = ($urandom_range(0, 9) < 2);
            bus.core_data_output  = 8'($urandom);
            bus.core_err_ptxt     = ($urandom_range(0, 31) == 0);
            bus.core_err_seckey   = ($urandom_range(0, 31) == 0);
            bus.core_err_ctxt     = ($urandom_range(0, 31) == 0);
            step();
        end
`ifdef SAE_ARBITER_STATS_EN
        check("stats_grant_cnt0_rand", grant_cnt0, m_grants[0]);
        check("stats_grant_cnt1_rand", grant_cnt1, m_grants[1]);
        check("stats_timeout_cnt_rand", timeout_cnt, m_tmo);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sae_arbiter.md
SAE_ARBITER -- requirements
Module: sae_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 8, max cycles waited in WAIT for a core response (legal 1..255).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_mode  in  2  01 pubkey-gen, 10 encrypt, 11 decrypt; 00 = no operation.
REQ-006 reqN_data  in  8  data_input operand; reqN_key  in  8  key_input operand.
REQ-007 reqN_ready  out  1  one-cycle accept pulse; operands latched that cycle.
REQ-008 rspN_valid  out  1  one-cycle response strobe to requester N.
REQ-009 rspN_data  out  8  captured core data_output; rspN_err  out  4  {timeout, ctxt, seckey, ptxt}.
REQ-010 core_mode  out  2;  core_data_input  out  8;  core_key_input  out  8;  core_inputs_valid  out  1  drive shared sae core.
REQ-011 core_data_output  in  8;  core_output_ready  in  1;  core_err_ptxt, core_err_seckey, core_err_ctxt  in  1 each  from sae core.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at most.
REQ-013 IDLE: requester eligible iff reqN_valid=1 and reqN_mode!=00; mode 00 never granted, reqN_ready stays 0.
REQ-014 Arbitration round-robin: last_grant bit; both eligible -> grant the one not last granted; one eligible -> grant it; after reset requester 0 has priority.
REQ-015 Grant cycle T (in IDLE): reqN_ready=1 for winner only, mode/data/key/id latched, next state ISSUE, last_grant updated.
REQ-016 ISSUE (T+1): core_inputs_valid=1, core_mode/data/key = latched values; next WAIT, timeout counter cleared.
REQ-017 WAIT: core_mode/data/key held stable, core_inputs_valid=0; counter increments each cycle.
REQ-018 WAIT exit on core_output_ready=1 or any core_err_*=1: capture core_data_output and three error bits, timeout bit 0, go RESP.
REQ-019 Counter reaching TIMEOUT_CYCLES with no completion: capture data 0x00, err=4'b1000, go RESP.
REQ-020 RESP: rspN_valid=1 for latched id only, rspN_data/err stable that cycle; core_mode=00; next IDLE.
REQ-021 Nominal core (output_ready one cycle after inputs_valid): accept T, rsp_valid T+3; throughput one op per 4 cycles.
REQ-022 core_mode=00, core_inputs_valid=0 in IDLE and RESP.
REQ-023 rspN_data/rspN_err hold last captured value between strobes; other requester's rsp outputs unaffected.
REQ-024 Requester dropping reqN_valid after accept does not cancel the operation; response still issued.
REQ-025 reqN_valid asserted during ISSUE/WAIT/RESP waits; no ready until IDLE.
REQ-026 core_output_ready and counter expiry in same cycle: completion wins, timeout bit 0.

Reset
REQ-027 rst_n low: state IDLE, all outputs 0 (ready, rsp_valid, rsp_data, rsp_err, core_* ), counter 0, last_grant selects requester 0 first, latched operands 0.
REQ-028 Reset mid-operation aborts it immediately: no rsp_valid issued, core_inputs_valid drops asynchronously.

Configuration
REQ-029 Macro SAE_ARBITER_STATS_EN defined: outputs grant_cnt0, grant_cnt1 (16 bit, saturating at 0xFFFF, +1 per grant) and timeout_cnt (8 bit, saturating), all reset to 0.
REQ-030 Macro undefined: these ports and counters absent; all other behaviour identical.

Verification
REQ-031 Single: req0 mode 01 key 0x2B, core ready 1 cycle after valid with data 0x5C -> ready0 at T, core_inputs_valid T+1, rsp0_valid T+3, rsp0_data 0x5C, err 0.
REQ-032 Contention: req0 and req1 both mode 10 from reset -> grants 0,1,0,1 alternating, each rsp to correct port, no overlap of core_inputs_valid.
REQ-033 Error: req1 mode 11, core asserts err_ctxt with output_ready -> rsp1_err=4'b0100, rsp1_valid once.
REQ-034 Timeout: TIMEOUT_CYCLES=8, core silent -> rsp0_err=4'b1000, rsp0_data 0x00, back to IDLE; timeout_cnt=1 with macro.
REQ-035 Mode 00: req0_valid=1 mode 00 for 20 cycles -> no ready0, core_inputs_valid never 1.
REQ-036 Reset during WAIT -> all outputs 0, no rsp; next request from both granted to requester 0.
